// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL types for the SRAM responder: channel opcodes, the queued
// response descriptor and the byte-lane window helper used by the legality check.
package tl_ul_pkg;

    localparam int TL_SZW      = 3;
    localparam int TL_SRCW     = 4;
    localparam int TL_MASK_MAX = 128;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    typedef struct packed {
        d_opcode_e           opcode;
        logic [TL_SZW-1:0]   size;
        logic [TL_SRCW-1:0]  source;
        logic                denied;
        logic                is_get;
    } resp_entry_t;

    // Byte lanes a request of 2**size bytes at byte offset 'offset' may touch.
    function automatic logic [TL_MASK_MAX-1:0] mask_window(input int size, input int offset);
        logic [TL_MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < TL_MASK_MAX; i++) begin
            m[i] = (i >= offset) && (i < offset + (1 << size));
        end
        return m;
    endfunction

endpackage

// File: rtl/tl_ul_resp_fifo.sv
// Circular response queue. Metadata is written when an entry is allocated; read
// data arrives one cycle later through the fill port and is bypassed to the head.
module tl_ul_resp_fifo
    import tl_ul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 64,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push_i,
    input  resp_entry_t   push_entry_i,
    output logic [PW-1:0] push_ptr_o,
    input  logic          pop_i,
    input  logic          fill_i,
    input  logic [PW-1:0] fill_ptr_i,
    input  logic [DW-1:0] fill_data_i,
    output resp_entry_t   head_o,
    output logic [DW-1:0] head_data_o,
    output logic          empty_o,
    output logic [CW-1:0] cnt_next_o
);

    resp_entry_t   meta_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) meta_q[wr_ptr_q] <= push_entry_i;
        if (fill_i) data_q[fill_ptr_i] <= fill_data_i;
    end

    assign push_ptr_o  = wr_ptr_q;
    assign head_o      = meta_q[rd_ptr_q];
    assign head_data_o = (fill_i && (fill_ptr_i == rd_ptr_q)) ? fill_data_i : data_q[rd_ptr_q];
    assign empty_o     = (cnt_q == '0);
    assign cnt_next_o  = cnt_d;

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL SRAM slave: single-beat Get/Put on A, in-order AccessAck(Data) on D.
// Define TL_UL_SRAM_RESPONDER_STALL_EN to add LFSR-driven pseudo-random backpressure.
module tl_ul_sram_responder
    import tl_ul_pkg::*;
#(
    parameter int            DW         = 64,
    parameter int            AW         = 32,
    parameter int            SRCW       = TL_SRCW,
    parameter int            SZW        = TL_SZW,
    parameter int            DEPTH      = 256,
    parameter logic [AW-1:0] BASE       = 'h0800_0000,
    parameter int            RESP_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [2:0]      a_opcode,
    input  logic [2:0]      a_param,
    input  logic [SZW-1:0]  a_size,
    input  logic [SRCW-1:0] a_source,
    input  logic [AW-1:0]   a_address,
    input  logic [DW/8-1:0] a_mask,
    input  logic [DW-1:0]   a_data,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [2:0]      d_opcode,
    output logic [1:0]      d_param,
    output logic [SZW-1:0]  d_size,
    output logic [SRCW-1:0] d_source,
    output logic            d_denied,
    output logic [DW-1:0]   d_data,
    output logic            d_corrupt
);

    localparam int NBYTES    = DW / 8;
    localparam int LG_BYTES  = $clog2(NBYTES);
    localparam int IDXW      = $clog2(DEPTH);
    localparam int REGION_LG = IDXW + LG_BYTES;
    localparam int PW        = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW        = $clog2(RESP_DEPTH + 1);

    logic [LG_BYTES-1:0] offset;
    logic [IDXW-1:0]     word_idx;
    logic                req_get, req_put, legal;
    logic                a_fire, d_fire;
    logic                a_ready_q, fill_q, empty;
    logic [PW-1:0]       push_ptr, fill_ptr_q;
    logic [CW-1:0]       cnt_next;
    logic [DW-1:0]       rdata_q, head_data;
    resp_entry_t         push_entry, head;
    logic [DW-1:0]       mem [DEPTH];

    assign offset   = a_address[LG_BYTES-1:0];
    assign word_idx = a_address[REGION_LG-1:LG_BYTES];

    // The region is naturally aligned, so the range check is a compare of the upper bits.
    always_comb begin
        logic align_ok;
        req_get  = (a_opcode == GET);
        req_put  = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
        align_ok = 1'b1;
        for (int i = 0; i < LG_BYTES; i++) begin
            if ((i < int'(a_size)) && offset[i]) align_ok = 1'b0;
        end
        legal = (req_get || req_put)
             && (a_param == 3'd0)
             && (int'(a_size) <= LG_BYTES)
             && align_ok
             && (a_address[AW-1:REGION_LG] == BASE[AW-1:REGION_LG])
             && ((TL_MASK_MAX'(a_mask) & ~mask_window(int'(a_size), int'(offset))) == '0);
    end

    always_comb begin
        push_entry        = '0;
        push_entry.opcode = req_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        push_entry.size   = a_size;
        push_entry.source = a_source;
        push_entry.denied = !legal;
        push_entry.is_get = req_get;
    end

    assign a_fire = a_valid && a_ready;
    assign d_fire = d_valid && d_ready;

    always_ff @(posedge clock) begin
        if (a_fire && legal && req_put) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (a_mask[b]) mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
            end
        end
        if (a_fire && legal && req_get) rdata_q <= mem[word_idx];
    end

    // a_ready is a flop of the next credit count, keeping d_ready off any path to it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_ready_q  <= 1'b0;
            fill_q     <= 1'b0;
            fill_ptr_q <= '0;
        end else begin
            a_ready_q  <= (cnt_next < CW'(RESP_DEPTH));
            fill_q     <= a_fire && legal && req_get;
            fill_ptr_q <= push_ptr;
        end
    end

    tl_ul_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .DW    (DW),
        .PW    (PW),
        .CW    (CW)
    ) u_resp_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_i       (a_fire),
        .push_entry_i (push_entry),
        .push_ptr_o   (push_ptr),
        .pop_i        (d_fire),
        .fill_i       (fill_q),
        .fill_ptr_i   (fill_ptr_q),
        .fill_data_i  (rdata_q),
        .head_o       (head),
        .head_data_o  (head_data),
        .empty_o      (empty),
        .cnt_next_o   (cnt_next)
    );

`ifdef TL_UL_SRAM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;
    logic        d_shown_q;
    logic        stall;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr_q    <= 16'hACE1;
            d_shown_q <= 1'b0;
        end else begin
            lfsr_q    <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            d_shown_q <= d_valid && !d_ready;
        end
    end

    // A response already on the bus is never withdrawn by a stall.
    assign stall   = (lfsr_q[1:0] == 2'b00);
    assign a_ready = a_ready_q && !stall;
    assign d_valid = !empty && (!stall || d_shown_q);
`else
    assign a_ready = a_ready_q;
    assign d_valid = !empty;
`endif

    always_comb begin
        d_opcode  = '0;
        d_param   = '0;
        d_size    = '0;
        d_source  = '0;
        d_denied  = 1'b0;
        d_data    = '0;
        d_corrupt = 1'b0;
        if (d_valid) begin
            d_opcode  = head.opcode;
            d_size    = head.size;
            d_source  = head.source;
            d_denied  = head.denied;
            d_corrupt = head.is_get && head.denied;
            d_data    = (head.is_get && !head.denied) ? head_data : '0;
        end
    end

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder: expected D responses are queued at
// accept time and popped by an independent monitor on every D handshake.
module tb_tl_ul_sram_responder;

    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam int SRCW = 4;
    localparam int SZW  = 3;
    localparam int W    = 3 + 2 + SRCW + SZW + 1 + 1 + DW;

    localparam logic [2:0] OP_PF   = 3'd0;
    localparam logic [2:0] OP_PP   = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] ACK     = 3'd0;
    localparam logic [2:0] ACKD    = 3'd1;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            a_valid;
    logic            a_ready;
    logic [2:0]      a_opcode;
    logic [2:0]      a_param;
    logic [SZW-1:0]  a_size;
    logic [SRCW-1:0] a_source;
    logic [AW-1:0]   a_address;
    logic [DW/8-1:0] a_mask;
    logic [DW-1:0]   a_data;
    logic            d_valid;
    logic            d_ready;
    logic [2:0]      d_opcode;
    logic [1:0]      d_param;
    logic [SZW-1:0]  d_size;
    logic [SRCW-1:0] d_source;
    logic            d_denied;
    logic [DW-1:0]   d_data;
    logic            d_corrupt;

    tl_ul_sram_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    logic [W-1:0] exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] d_now;
    logic [W-1:0] mon_exp;
    logic [W-1:0] held;
    logic         hold_prev = 1'b0;

    assign d_now = {d_opcode, d_param, d_source, d_size, d_denied, d_corrupt, d_data};

    function automatic logic [W-1:0] resp(input logic [2:0] op, input logic [SRCW-1:0] src,
                                          input logic [SZW-1:0] size, input logic den,
                                          input logic cor, input logic [DW-1:0] data);
        return {op, 2'b00, src, size, den, cor, data};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Driver: present one A request (called just after a falling edge) and queue its response.
    task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [SZW-1:0] size,
                        input logic [SRCW-1:0] src, input logic [AW-1:0] addr,
                        input logic [DW/8-1:0] mask, input logic [DW-1:0] data,
                        input logic [W-1:0] exp);
        int waited = 0;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = param;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        while (!a_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (a_ready) begin
            exp_q.push_back(exp);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout src=%0d: a_ready stayed 0, required 1", src);
        end
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d responses outstanding, required 0", name, exp_q.size());
        end
    endtask

    // Monitor: handshake and stability checks, sampled just after the falling edge.
    always begin
        @(negedge clock);
        #1;
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                vectors++;
                if (!d_valid || d_now !== held) begin
                    miscompares++;
                    $display("FAIL d_stable: got valid=%0b %h, required valid=1 %h", d_valid, d_now, held);
                end
            end
            if (d_valid && d_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL d_unexpected: got response %h, required none", d_now);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (d_now !== mon_exp) begin
                        miscompares++;
                        $display("FAIL d_resp: got %h, required %h", d_now, mon_exp);
                    end
                end
            end
            hold_prev = d_valid && !d_ready;
            held      = d_now;
        end
    end

    initial begin
        int c0;
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_param   = '0;
        a_size    = '0;
        a_source  = '0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        d_ready   = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_a_ready", 64'(a_ready), 64'd0);
        check("reset_d_valid", 64'(d_valid), 64'd0);
        check("reset_d_fields", 64'({d_opcode, d_source, d_size, d_denied, d_corrupt}), 64'd0);
        check("reset_d_data", d_data, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("a_ready_after_reset", 64'(a_ready), 64'd1);

        // Basic write/read and one-cycle latency.
        send(OP_PF, 3'd0, 3'd3, 4'd3, 32'h0800_0010, 8'hFF, 64'h1122334455667788,
             resp(ACK, 4'd3, 3'd3, 1'b0, 1'b0, 64'd0));
        check("latency_d_valid", 64'(d_valid), 64'd1);
        send(OP_GET, 3'd0, 3'd3, 4'd5, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACKD, 4'd5, 3'd3, 1'b0, 1'b0, 64'h1122334455667788));

        // Four back-to-back requests with d_ready high take four cycles.
        c0 = cyc;
        send(OP_PP, 3'd0, 3'd3, 4'd1, 32'h0800_0010, 8'h0F, 64'hAAAAAAAAAAAAAAAA,
             resp(ACK, 4'd1, 3'd3, 1'b0, 1'b0, 64'd0));
        send(OP_GET, 3'd0, 3'd3, 4'd2, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACKD, 4'd2, 3'd3, 1'b0, 1'b0, 64'h11223344AAAAAAAA));
        send(OP_PF, 3'd0, 3'd3, 4'd6, 32'h0800_0014, 8'hFF, 64'hDEADBEEFDEADBEEF,
             resp(ACK, 4'd6, 3'd3, 1'b1, 1'b0, 64'd0));
        send(OP_GET, 3'd0, 3'd3, 4'd2, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACKD, 4'd2, 3'd3, 1'b0, 1'b0, 64'h11223344AAAAAAAA));
        check("throughput_cycles", 64'(cyc - c0), 64'd4);

        // Legality boundaries.
        send(OP_GET, 3'd0, 3'd3, 4'd7, 32'h0900_0000, 8'hFF, 64'd0,
             resp(ACKD, 4'd7, 3'd3, 1'b1, 1'b1, 64'd0));
        send(OP_GET, 3'd0, 3'd3, 4'd4, 32'h0800_0004, 8'hFF, 64'd0,
             resp(ACKD, 4'd4, 3'd3, 1'b1, 1'b1, 64'd0));
        send(3'd2, 3'd0, 3'd3, 4'd6, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACK, 4'd6, 3'd3, 1'b1, 1'b0, 64'd0));
        send(3'd7, 3'd0, 3'd3, 4'd0, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACK, 4'd0, 3'd3, 1'b1, 1'b0, 64'd0));
        send(OP_GET, 3'd1, 3'd3, 4'd8, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACKD, 4'd8, 3'd3, 1'b1, 1'b1, 64'd0));
        send(OP_GET, 3'd0, 3'd2, 4'd9, 32'h0800_0010, 8'hF0, 64'd0,
             resp(ACKD, 4'd9, 3'd2, 1'b1, 1'b1, 64'd0));
        send(OP_GET, 3'd0, 3'd2, 4'd10, 32'h0800_0014, 8'hF0, 64'd0,
             resp(ACKD, 4'd10, 3'd2, 1'b0, 1'b0, 64'h11223344AAAAAAAA));
        send(OP_GET, 3'd0, 3'd4, 4'd11, 32'h0800_0000, 8'hFF, 64'd0,
             resp(ACKD, 4'd11, 3'd4, 1'b1, 1'b1, 64'd0));
        send(OP_PF, 3'd0, 3'd3, 4'd12, 32'h0800_07F8, 8'hFF, 64'h0123456789ABCDEF,
             resp(ACK, 4'd12, 3'd3, 1'b0, 1'b0, 64'd0));
        send(OP_GET, 3'd0, 3'd3, 4'd13, 32'h0800_07F8, 8'hFF, 64'd0,
             resp(ACKD, 4'd13, 3'd3, 1'b0, 1'b0, 64'h0123456789ABCDEF));
        send(OP_GET, 3'd0, 3'd3, 4'd14, 32'h0800_0800, 8'hFF, 64'd0,
             resp(ACKD, 4'd14, 3'd3, 1'b1, 1'b1, 64'd0));
        send(OP_GET, 3'd0, 3'd3, 4'd15, 32'h07FF_FFF8, 8'hFF, 64'd0,
             resp(ACKD, 4'd15, 3'd3, 1'b1, 1'b1, 64'd0));
        send(OP_PP, 3'd0, 3'd0, 4'd1, 32'h0800_0013, 8'h08, 64'h0000000055000000,
             resp(ACK, 4'd1, 3'd0, 1'b0, 1'b0, 64'd0));
        send(OP_GET, 3'd0, 3'd3, 4'd2, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACKD, 4'd2, 3'd3, 1'b0, 1'b0, 64'h1122334455AAAAAA));
        drain("drain_legality");

        // Backpressure: two accepts fill the queue, the third waits for a D fire.
        d_ready = 1'b0;
        send(OP_GET, 3'd0, 3'd3, 4'd3, 32'h0800_0010, 8'hFF, 64'd0,
             resp(ACKD, 4'd3, 3'd3, 1'b0, 1'b0, 64'h1122334455AAAAAA));
        send(OP_GET, 3'd0, 3'd3, 4'd4, 32'h0800_07F8, 8'hFF, 64'd0,
             resp(ACKD, 4'd4, 3'd3, 1'b0, 1'b0, 64'h0123456789ABCDEF));
        fork
            send(OP_GET, 3'd0, 3'd3, 4'd5, 32'h0800_0010, 8'hFF, 64'd0,
                 resp(ACKD, 4'd5, 3'd3, 1'b0, 1'b0, 64'h1122334455AAAAAA));
            begin
                repeat (3) @(negedge clock);
                check("full_a_ready", 64'(a_ready), 64'd0);
                check("full_d_valid", 64'(d_valid), 64'd1);
                check("full_head_src", 64'(d_source), 64'd3);
                d_ready = 1'b1;
                @(negedge clock);
                check("a_ready_after_d_fire", 64'(a_ready), 64'd1);
            end
        join
        drain("drain_backpressure");

        // Reset with two responses queued drops them.
        d_ready = 1'b0;
        send(OP_PF, 3'd0, 3'd3, 4'd1, 32'h0800_0020, 8'hFF, 64'hCAFEF00D12345678,
             resp(ACK, 4'd1, 3'd3, 1'b0, 1'b0, 64'd0));
        send(OP_PF, 3'd0, 3'd3, 4'd2, 32'h0800_0028, 8'hFF, 64'h0F0F0F0F0F0F0F0F,
             resp(ACK, 4'd2, 3'd3, 1'b0, 1'b0, 64'd0));
        check("queued_before_reset", 64'(d_valid), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("mid_reset_d_valid", 64'(d_valid), 64'd0);
        check("mid_reset_a_ready", 64'(a_ready), 64'd0);
        d_ready = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_a_ready", 64'(a_ready), 64'd1);
        check("post_reset_d_valid", 64'(d_valid), 64'd0);
        repeat (3) @(negedge clock);
        check("no_stale_d_valid", 64'(d_valid), 64'd0);
        send(OP_GET, 3'd0, 3'd3, 4'd6, 32'h0800_0020, 8'hFF, 64'd0,
             resp(ACKD, 4'd6, 3'd3, 1'b0, 1'b0, 64'hCAFEF00D12345678));
        drain("drain_final");

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL (Uncached Lightweight) slave endpoint. Accepts single-beat Get/PutFullData/PutPartialData on channel A, commits them to an internal SRAM array, returns AccessAck/AccessAckData on channel D.
- Serves as the manager-side responder paired with the bus protocol monitors on the eval subsystem's peripheral port.
- Its D-channel output must keep the monitor's source/size-echo and legality checks silent.

Parameters:
- DW, 64, data width in bits (power of 2, >=32)
- AW, 32, address width
- SRCW, 4, source ID width
- SZW, 3, size field width
- DEPTH, 256, SRAM words (power of 2)
- BASE, 32'h0800_0000, base address; region size = DEPTH*DW/8, naturally aligned
- RESP_DEPTH, 2, response queue entries (>=2)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted when a_valid&a_ready
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- a_param  in  3  must be 0
- a_size  in  SZW  log2 bytes
- a_source  in  SRCW  requester ID
- a_address  in  AW  byte address
- a_mask  in  DW/8  byte lanes
- a_data  in  DW  write data
- d_valid  out  1  D response valid
- d_ready  in  1  D response consumed when d_valid&d_ready
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  SZW  echo of a_size
- d_source  out  SRCW  echo of a_source
- d_denied  out  1  request rejected
- d_data  out  DW  read data (0 when not AccessAckData or denied)
- d_corrupt  out  1  equals d_denied on AccessAckData, else 0

Behaviour:
- Reset (reset_n=0 at a clock edge): a_ready=0 during reset, 1 on the first cycle after deassertion; d_valid=0; all d_* fields 0; queue and credit counter cleared. SRAM contents are not reset. Reset mid-transaction drops all in-flight responses.
- Credit counter cnt: counts queued plus in-flight responses, range 0..RESP_DEPTH.
  - Increments on A fire; decrements on D fire; both in one cycle leaves it unchanged.
  - a_ready = (cnt < RESP_DEPTH), registered-equivalent. There is no combinational path from d_ready to a_ready.
- Legality check on accept. The request is denied if any of the following hold:
  - opcode not in {0,1,4}
  - a_param != 0
  - a_size > log2(DW/8)
  - address misaligned to a_size
  - address outside [BASE, BASE+region)
  - a_mask bits outside the size/offset window
- Denied Put: no SRAM write. Denied Get: no SRAM read, d_data=0.
- Legal Put: SRAM write in the accept cycle, byte-enabled by a_mask. PutFull and PutPartial behave the same internally.
- Legal Get: synchronous SRAM read in the accept cycle. Data is captured into the queue entry on the following cycle.
- Response opcode follows the request type, not legality: Get gives AccessAckData; Put gives AccessAck; an illegal opcode gives AccessAck with d_denied=1.
- Latency: accept in cycle N gives earliest d_valid in N+1. With d_ready held high, throughput is 1 request/cycle.
- Ordering: responses return in strict accept order. Put then Get to the same address in consecutive cycles must return the new data.
- D handshake: once d_valid=1, all d_* fields hold stable until d_ready=1. d_valid never drops without a fire.
- Queue full (cnt==RESP_DEPTH): a_ready=0. On the cycle a D fire occurs, a_ready rises on the next cycle.

Optional Feature:
- Macro: TL_UL_SRAM_RESPONDER_STALL_EN.
- Defined: a 16-bit LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, re-seeded on reset) advances every cycle. While lfsr[1:0]==2'b00, a_ready is forced to 0 and d_valid is withheld, but only if d_valid was not already asserted, so stability is preserved. Used for bench backpressure.
- Undefined: no LFSR logic; behaviour exactly as above.

Decomposition:
- Package tl_ul_pkg:
  - opcode enums for A (PUT_FULL=0, PUT_PARTIAL=1, GET=4) and D (ACCESS_ACK=0, ACCESS_ACK_DATA=1)
  - response-entry struct {opcode, size, source, denied, is_get}
  - helper function for the size/offset mask window
- Sub-module tl_ul_resp_fifo:
  - parameterised RESP_DEPTH circular buffer
  - separate data-fill write one cycle after entry allocation, to handle read latency

Test Plan:
- After reset, PutFull addr 0x0800_0010, data 0x1122334455667788, mask 0xFF, source 3; then Get same address, source 5 -> AccessAck src 3 denied 0; then AccessAckData src 5 data 0x1122334455667788.
- PutPartial mask 0x0F, data 0xAAAAAAAAAAAAAAAA, onto the word above; then Get -> data 0x11223344AAAAAAAA.
- Get addr 0x0900_0000 (out of range), size 3, source 7 -> AccessAckData, d_denied=1, d_corrupt=1, d_data=0, SRAM unchanged.
- Get addr 0x0800_0004, size 3 (misaligned) -> denied. Opcode 2 -> AccessAck denied=1.
- d_ready=0 while issuing 3 back-to-back Gets -> a_ready drops after 2 accepts. d_* stay stable. Releasing d_ready drains in order; a_ready returns the cycle after the first D fire.
- reset_n=0 mid-drain with 2 responses queued -> next cycle d_valid=0; after release, a_ready=1 and no stale responses appear.
